// File: rtl/load_align_pkg.sv
// Shared types for the load alignment path.
//   size_e  : access size encoding as presented by the LSU (byte/half/word/dword)
//   state_e : bus sequencing FSM states of load_align_unit
package load_align_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ0  = 3'd1,
      ST_WAIT0 = 3'd2,
      ST_REQ1  = 3'd3,
      ST_WAIT1 = 3'd4,
      ST_RESP  = 3'd5
   } state_e;

endpackage

// File: rtl/load_extract.sv
// Combinational datum extraction for loads.
// Shifts the two-beat window {beat1, beat0} right by the byte offset, keeps the low
// 1<<size bytes and fills the remaining bytes with the datum sign bit (signext=1) or zero.
// Ports:
//   beat0, beat1 : first and second bus beats (beat1 is don't-care for non-crossing loads)
//   off          : byte offset of the load inside beat0
//   size         : access size
//   signext      : 1 = sign-extend, 0 = zero-extend
//   data         : right-justified, extended result
module load_extract
   import load_align_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0]              beat0,
   input  logic [XLEN-1:0]              beat1,
   input  logic [$clog2(XLEN/8)-1:0]    off,
   input  size_e                        size,
   input  logic                         signext,
   output logic [XLEN-1:0]              data
);

   localparam int unsigned BYTES = XLEN / 8;
   localparam int unsigned IDX_W = $clog2(2 * XLEN);

   logic [2*XLEN-1:0] shifted;
   logic [IDX_W-1:0]  msb_idx;
   logic              fill;
   int unsigned       nbytes;

   always_comb begin
      shifted = {beat1, beat0} >> {off, 3'b000};
      nbytes  = 32'd1 << size;
      msb_idx = IDX_W'((32'd8 << size) - 32'd1);
      fill    = signext & shifted[msb_idx];
      data    = '0;
      // Bytes beyond the datum become the fill byte; a full-width access leaves none.
      for (int unsigned i = 0; i < BYTES; i++) begin
         data[8*i +: 8] = (i < nbytes) ? shifted[8*i +: 8] : {8{fill}};
      end
   end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit between the execute-stage LSU and the data-memory port.
// Accepts byte/half/word/dword loads at any byte address, issues naturally aligned bus
// reads and returns the right-justified, zero/sign-extended datum.
// Build option: define LOAD_SPLIT_EN to service loads that cross a bus-word boundary with
// two bus beats; without it such loads answer immediately with rsp_fault=1 and no bus access.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr/
//   req_size/req_signext              : load request from the LSU
//   mem_req_valid/mem_req_ready/
//   mem_addr                          : aligned bus read request
//   mem_rvalid/mem_rdata              : in-order read data, one beat per request
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_fault                         : load response
module load_align_unit
   import load_align_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_signext,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_data,
   output logic              rsp_fault
);

   localparam int unsigned BYTES = XLEN / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);

   state_e            state;
   logic [OFF_W-1:0]  off_q;
   size_e             size_q;
   logic              signext_q;
   logic [XLEN-1:0]   beat0_q;
   logic [XLEN-1:0]   ext_beat0;
   logic [XLEN-1:0]   ext_data;
   logic [ADDR_W-1:0] req_align;
   int unsigned       req_nbytes;
   logic              req_cross;
   logic              req_bad;
`ifdef LOAD_SPLIT_EN
   logic              cross_q;
`endif

   assign req_ready  = (state == ST_IDLE);
   assign req_align  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign req_nbytes = 32'd1 << req_size;
   assign req_cross  = (32'(req_addr[OFF_W-1:0]) + req_nbytes) > BYTES;

`ifdef LOAD_SPLIT_EN
   assign req_bad = (XLEN == 32) && (size_e'(req_size) == SZ_D);
`else
   assign req_bad = ((XLEN == 32) && (size_e'(req_size) == SZ_D)) || req_cross;
`endif

   // In WAIT0 the beat is still on the bus; later states use the buffered copy.
   assign ext_beat0 = (state == ST_WAIT0) ? mem_rdata : beat0_q;

   load_extract #(
      .XLEN (XLEN)
   ) u_extract (
      .beat0   (ext_beat0),
      .beat1   (mem_rdata),
      .off     (off_q),
      .size    (size_q),
      .signext (signext_q),
      .data    (ext_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         off_q         <= '0;
         size_q        <= SZ_B;
         signext_q     <= 1'b0;
         beat0_q       <= '0;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         rsp_fault     <= 1'b0;
`ifdef LOAD_SPLIT_EN
         cross_q       <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  off_q     <= req_addr[OFF_W-1:0];
                  size_q    <= size_e'(req_size);
                  signext_q <= req_signext;
`ifdef LOAD_SPLIT_EN
                  cross_q   <= req_cross;
`endif
                  if (req_bad) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_fault <= 1'b1;
                     rsp_data  <= '0;
                  end else begin
                     state         <= ST_REQ0;
                     mem_req_valid <= 1'b1;
                     mem_addr      <= req_align;
                  end
               end
            end
            ST_REQ0: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= ST_WAIT0;
               end
            end
            ST_WAIT0: begin
               if (mem_rvalid) begin
                  beat0_q <= mem_rdata;
`ifdef LOAD_SPLIT_EN
                  if (cross_q) begin
                     state         <= ST_REQ1;
                     mem_req_valid <= 1'b1;
                     mem_addr      <= mem_addr + ADDR_W'(BYTES);
                  end else begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_fault <= 1'b0;
                     rsp_data  <= ext_data;
                  end
`else
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_fault <= 1'b0;
                  rsp_data  <= ext_data;
`endif
               end
            end
`ifdef LOAD_SPLIT_EN
            ST_REQ1: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= ST_WAIT1;
               end
            end
            ST_WAIT1: begin
               if (mem_rvalid) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_fault <= 1'b0;
                  rsp_data  <= ext_data;
               end
            end
`endif
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state         <= ST_IDLE;
               mem_req_valid <= 1'b0;
               rsp_valid     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: one XLEN=32 and one XLEN=64 instance share clock
// and reset. Bus responders return one registered beat per accepted request from small
// address/data tables set up by each test. Crossing-load expectations follow LOAD_SPLIT_EN.
module tb_load_align_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // XLEN=32 instance
   logic        r32_valid = 1'b0, r32_ready, r32_sx = 1'b0;
   logic [31:0] r32_addr = '0;
   logic [1:0]  r32_size = '0;
   logic        m32_req_valid, m32_req_ready = 1'b1, m32_rvalid = 1'b0;
   logic [31:0] m32_addr, m32_rdata = '0;
   logic        s32_valid, s32_ready = 1'b1, s32_fault;
   logic [31:0] s32_data;

   // XLEN=64 instance
   logic        r64_valid = 1'b0, r64_ready, r64_sx = 1'b0;
   logic [31:0] r64_addr = '0;
   logic [1:0]  r64_size = '0;
   logic        m64_req_valid, m64_req_ready = 1'b1, m64_rvalid = 1'b0;
   logic [31:0] m64_addr;
   logic [63:0] m64_rdata = '0;
   logic        s64_valid, s64_ready = 1'b1, s64_fault;
   logic [63:0] s64_data;

   // Memory tables and responder bookkeeping
   logic [31:0] m32_a0 = '0, m32_a1 = '0, m32_d0 = '0, m32_d1 = '0;
   logic [31:0] m64_a0 = '0;
   logic [63:0] m64_d0 = '0;
   int          resp_limit32 = 1000000;
   int          n32_req = 0, n32_resp = 0, n64_req = 0, n64_rsp = 0;
   logic [31:0] last32_addr = '0, prev32_addr = '0;

   int checks = 0;
   int failures = 0;

   load_align_unit #(.XLEN(32), .ADDR_W(32)) u_dut32 (
      .clk (clk), .rst_n (rst_n),
      .req_valid (r32_valid), .req_ready (r32_ready), .req_addr (r32_addr),
      .req_size (r32_size), .req_signext (r32_sx),
      .mem_req_valid (m32_req_valid), .mem_req_ready (m32_req_ready), .mem_addr (m32_addr),
      .mem_rvalid (m32_rvalid), .mem_rdata (m32_rdata),
      .rsp_valid (s32_valid), .rsp_ready (s32_ready), .rsp_data (s32_data),
      .rsp_fault (s32_fault)
   );

   load_align_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
      .clk (clk), .rst_n (rst_n),
      .req_valid (r64_valid), .req_ready (r64_ready), .req_addr (r64_addr),
      .req_size (r64_size), .req_signext (r64_sx),
      .mem_req_valid (m64_req_valid), .mem_req_ready (m64_req_ready), .mem_addr (m64_addr),
      .mem_rvalid (m64_rvalid), .mem_rdata (m64_rdata),
      .rsp_valid (s64_valid), .rsp_ready (s64_ready), .rsp_data (s64_data),
      .rsp_fault (s64_fault)
   );

   always @(posedge clk) begin
      m32_rvalid <= 1'b0;
      if (m32_req_valid && m32_req_ready) begin
         n32_req     <= n32_req + 1;
         prev32_addr <= last32_addr;
         last32_addr <= m32_addr;
         if (n32_resp < resp_limit32) begin
            n32_resp   <= n32_resp + 1;
            m32_rvalid <= 1'b1;
            m32_rdata  <= (m32_addr == m32_a0) ? m32_d0 :
                          (m32_addr == m32_a1) ? m32_d1 : 32'hDEAD_BEEF;
         end
      end
   end

   always @(posedge clk) begin
      m64_rvalid <= 1'b0;
      if (m64_req_valid && m64_req_ready) begin
         n64_req    <= n64_req + 1;
         m64_rvalid <= 1'b1;
         m64_rdata  <= (m64_addr == m64_a0) ? m64_d0 : 64'hDEAD_BEEF_DEAD_BEEF;
      end
      if (s64_valid && s64_ready) n64_rsp <= n64_rsp + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One XLEN=32 load with no stalls; lat counts the accept cycle as 1.
   task automatic load32(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sx, input logic [31:0] exp_d, input logic exp_f,
                         input int exp_lat, input int exp_nreq);
      int n0;
      int lat;
      n0 = n32_req;
      check_eq({tag, " req_ready idle"}, 64'(r32_ready), 64'd1);
      r32_valid = 1'b1;
      r32_addr  = a;
      r32_size  = sz;
      r32_sx    = sx;
      lat       = 1;
      do begin
         @(negedge clk);
         r32_valid = 1'b0;
         lat++;
      end while (!s32_valid && lat < 40);
      check_eq({tag, " rsp_valid"}, 64'(s32_valid), 64'd1);
      check_eq({tag, " data"}, 64'(s32_data), 64'(exp_d));
      check_eq({tag, " fault"}, 64'(s32_fault), 64'(exp_f));
      check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, " req_ready busy"}, 64'(r32_ready), 64'd0);
      @(negedge clk);
      check_eq({tag, " rsp done"}, 64'(s32_valid), 64'd0);
      check_eq({tag, " req_ready next"}, 64'(r32_ready), 64'd1);
      check_eq({tag, " bus reqs"}, 64'(n32_req - n0), 64'(exp_nreq));
   endtask

   // One XLEN=64 load with optional bus-request and response back-pressure.
   task automatic load64(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sx, input int req_stall, input int rsp_stall,
                         input logic [63:0] exp_d, input int exp_lat);
      int n0;
      int r0;
      int lat;
      n0 = n64_req;
      r0 = n64_rsp;
      m64_req_ready = (req_stall == 0);
      s64_ready     = (rsp_stall == 0);
      check_eq({tag, " req_ready idle"}, 64'(r64_ready), 64'd1);
      r64_valid = 1'b1;
      r64_addr  = a;
      r64_size  = sz;
      r64_sx    = sx;
      lat       = 1;
      for (int i = 0; i < req_stall; i++) begin
         @(negedge clk);
         r64_valid = 1'b0;
         lat++;
         check_eq({tag, " stalled mem_req_valid"}, 64'(m64_req_valid), 64'd1);
         check_eq({tag, " stalled mem_addr"}, 64'(m64_addr), 64'({a[31:3], 3'b000}));
      end
      m64_req_ready = 1'b1;
      do begin
         @(negedge clk);
         r64_valid = 1'b0;
         lat++;
      end while (!s64_valid && lat < 40);
      check_eq({tag, " rsp_valid"}, 64'(s64_valid), 64'd1);
      check_eq({tag, " data"}, s64_data, exp_d);
      check_eq({tag, " fault"}, 64'(s64_fault), 64'd0);
      check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
      for (int i = 0; i < rsp_stall; i++) begin
         @(negedge clk);
         check_eq({tag, " held rsp_valid"}, 64'(s64_valid), 64'd1);
         check_eq({tag, " held data"}, s64_data, exp_d);
      end
      s64_ready = 1'b1;
      @(negedge clk);
      check_eq({tag, " rsp done"}, 64'(s64_valid), 64'd0);
      check_eq({tag, " bus reqs"}, 64'(n64_req - n0), 64'd1);
      check_eq({tag, " responses"}, 64'(n64_rsp - r0), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, " req_ready"}, 64'(r32_ready), 64'd1);
      check_eq({tag, " mem_req_valid"}, 64'(m32_req_valid), 64'd0);
      check_eq({tag, " mem_addr"}, 64'(m32_addr), 64'd0);
      check_eq({tag, " rsp_valid"}, 64'(s32_valid), 64'd0);
      check_eq({tag, " rsp_data"}, 64'(s32_data), 64'd0);
      check_eq({tag, " rsp_fault"}, 64'(s32_fault), 64'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      check_eq("reset r64 req_ready", 64'(r64_ready), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Non-crossing loads, XLEN=32
      m32_a0 = 32'h100; m32_d0 = 32'h80FF_1234;
      load32("lb 0x103", 32'h103, 2'd0, 1'b1, 32'hFFFF_FF80, 1'b0, 4, 1);
      check_eq("lb 0x103 bus addr", 64'(last32_addr), 64'h100);
      load32("lbu 0x101", 32'h101, 2'd0, 1'b0, 32'h0000_0012, 1'b0, 4, 1);
      m32_d0 = 32'hBEEF_0000;
      load32("lhu 0x102", 32'h102, 2'd1, 1'b0, 32'h0000_BEEF, 1'b0, 4, 1);
      load32("lh 0x102", 32'h102, 2'd1, 1'b1, 32'hFFFF_BEEF, 1'b0, 4, 1);
      load32("lw 0x100", 32'h100, 2'd2, 1'b1, 32'hBEEF_0000, 1'b0, 4, 1);

      // Reset while waiting on a bus beat abandons the load
      m32_a0 = 32'h1FC; m32_d0 = 32'hAAAA_1111;
      m32_a1 = 32'h200; m32_d1 = 32'h2222_BBBB;
`ifdef LOAD_SPLIT_EN
      resp_limit32 = n32_resp + 1;
      r32_addr = 32'h1FE;
`else
      resp_limit32 = n32_resp;
      r32_addr = 32'h1FC;
`endif
      r32_size  = 2'd2;
      r32_sx    = 1'b0;
      r32_valid = 1'b1;
      @(negedge clk);
      r32_valid = 1'b0;
      repeat (4) @(negedge clk);
`ifdef LOAD_SPLIT_EN
      check_eq("stuck mem_addr", 64'(m32_addr), 64'h200);
`else
      check_eq("stuck mem_addr", 64'(m32_addr), 64'h1FC);
`endif
      check_eq("stuck rsp_valid", 64'(s32_valid), 64'd0);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      resp_limit32 = 1000000;
      @(negedge clk);
      m32_a0 = 32'h100; m32_d0 = 32'h80FF_1234;
      load32("lb after reset", 32'h103, 2'd0, 1'b1, 32'hFFFF_FF80, 1'b0, 4, 1);

      // Crossing loads
      m32_a0 = 32'h1FC; m32_d0 = 32'hAAAA_1111;
      m32_a1 = 32'h200; m32_d1 = 32'h2222_BBBB;
`ifdef LOAD_SPLIT_EN
      load32("lw 0x1FE", 32'h1FE, 2'd2, 1'b0, 32'hBBBB_AAAA, 1'b0, 6, 2);
      check_eq("lw 0x1FE beat0 addr", 64'(prev32_addr), 64'h1FC);
      check_eq("lw 0x1FE beat1 addr", 64'(last32_addr), 64'h200);
      load32("lh 0x1FF", 32'h1FF, 2'd1, 1'b1, 32'hFFFF_BBAA, 1'b0, 6, 2);
`else
      load32("lw 0x1FE", 32'h1FE, 2'd2, 1'b0, 32'h0, 1'b1, 2, 0);
      load32("lh 0x1FF", 32'h1FF, 2'd1, 1'b1, 32'h0, 1'b1, 2, 0);
`endif
      m32_a0 = 32'h0; m32_d0 = 32'h7F00_0000;
      m32_a1 = 32'h4; m32_d1 = 32'h0000_0001;
      load32("lbu 0x3", 32'h3, 2'd0, 1'b0, 32'h0000_007F, 1'b0, 4, 1);
`ifdef LOAD_SPLIT_EN
      load32("lh 0x3", 32'h3, 2'd1, 1'b1, 32'h0000_017F, 1'b0, 6, 2);
`else
      load32("lh 0x3", 32'h3, 2'd1, 1'b1, 32'h0, 1'b1, 2, 0);
`endif
      m32_a0 = 32'hFFFF_FFFC; m32_d0 = 32'h5566_0000;
      m32_a1 = 32'h0;         m32_d1 = 32'h0000_7788;
`ifdef LOAD_SPLIT_EN
      load32("lw wrap", 32'hFFFF_FFFE, 2'd2, 1'b0, 32'h7788_5566, 1'b0, 6, 2);
      check_eq("lw wrap beat0 addr", 64'(prev32_addr), 64'hFFFF_FFFC);
      check_eq("lw wrap beat1 addr", 64'(last32_addr), 64'h0);
`else
      load32("lw wrap", 32'hFFFF_FFFE, 2'd2, 1'b0, 32'h0, 1'b1, 2, 0);
`endif
      load32("size3 on xlen32", 32'h0, 2'd3, 1'b0, 32'h0, 1'b1, 2, 0);

      // XLEN=64 with back-pressure on both sides
      m64_a0 = 32'h8; m64_d0 = 64'hF123_4567_89AB_CDEF;
      load64("ld 0x8 stalled", 32'h8, 2'd3, 1'b1, 3, 2, 64'hF123_4567_89AB_CDEF, 6);
      m64_d0 = 64'h8000_0001_2345_6789;
      load64("lw 0xC", 32'hC, 2'd2, 1'b1, 0, 0, 64'hFFFF_FFFF_8000_0001, 4);
      load64("lbu 0xF", 32'hF, 2'd0, 1'b0, 0, 0, 64'h80, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
